sensor_report_tx: RTL and testbench

Formats a snapshot of the current sensor and clock values into a fixed-length ASCII report line and streams it one byte at a time into the UART transmitter. It sits downstream of the watch, DHT11 and SR04 stages and upstream of the UART TX byte sender. One `start` pulse produces exactly one report line.

---
 rtl/sensor_report_tx.sv | 186 ++++++++++++++++++
 tb/tb_sensor_report_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_report_tx.sv
// Snapshots clock/sensor values on start and streams a fixed ASCII report line, one byte per handshake.
// Optional REPORT_CHECKSUM_EN inserts '*' and two uppercase hex digits (XOR of 'T'..last temp digit) before CR LF.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// SEND  | presenting frame byte idx, advancing on each accepted transfer
module sensor_report_tx #(
  parameter logic [7:0] SEP_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic [9:0] i_dist,
  input  logic [7:0] i_humi,
  input  logic [7:0] i_temp,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic       o_busy,
  output logic       o_done
);

`ifdef REPORT_CHECKSUM_EN
  localparam logic [4:0] LAST_IDX = 5'd27;
`else
  localparam logic [4:0] LAST_IDX = 5'd24;
`endif

  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_D     = 8'h44;
  localparam logic [7:0] CH_H     = 8'h48;
  localparam logic [7:0] CH_C     = 8'h43;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state, state_nxt;
  logic [4:0]  idx;
  logic [7:0]  hour_bcd, min_bcd, sec_bcd, humi_bcd, temp_bcd;
  logic [15:0] dist_bcd;
  logic [7:0]  frame_byte;
  logic        accept_start;
  logic        xfer;
  logic        last_xfer;
  logic        done_q;

  // Two-digit fields saturate at 99 before conversion.
  function automatic logic [7:0] to_bcd2(input logic [7:0] v);
    logic [7:0] s;
    logic [3:0] t, o;
    s = (v > 8'd99) ? 8'd99 : v;
    t = 4'(s / 8'd10);
    o = 4'(s % 8'd10);
    return {t, o};
  endfunction

  function automatic logic [15:0] to_bcd4(input logic [9:0] d);
    logic [3:0] th, hu, te, on;
    th = 4'(d / 10'd1000);
    hu = 4'((d / 10'd100) % 10'd10);
    te = 4'((d / 10'd10) % 10'd10);
    on = 4'(d % 10'd10);
    return {th, hu, te, on};
  endfunction

  function automatic logic [7:0] dig(input logic [3:0] n);
    return {4'h3, n};
  endfunction

  assign accept_start = (state == IDLE) && start;
  assign xfer         = (state == SEND) && i_tx_ready;
  assign last_xfer    = xfer && (idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start)     state_nxt = SEND;
      SEND: if (last_xfer) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state == SEND);
    o_tx_valid = (state == SEND);
    o_tx_data  = (state == SEND) ? frame_byte : 8'h00;
    o_done     = done_q;
  end

  // Snapshot is held in BCD so the byte mux is a pure select.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hour_bcd <= '0;
      min_bcd  <= '0;
      sec_bcd  <= '0;
      dist_bcd <= '0;
      humi_bcd <= '0;
      temp_bcd <= '0;
    end else if (accept_start) begin
      hour_bcd <= to_bcd2({2'b00, i_hour});
      min_bcd  <= to_bcd2({2'b00, i_min});
      sec_bcd  <= to_bcd2({2'b00, i_sec});
      dist_bcd <= to_bcd4(i_dist);
      humi_bcd <= to_bcd2(i_humi);
      temp_bcd <= to_bcd2(i_temp);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_xfer;
      if (accept_start)   idx <= '0;
      else if (last_xfer) idx <= '0;
      else if (xfer)      idx <= idx + 5'd1;
    end
  end

`ifdef REPORT_CHECKSUM_EN
  logic [7:0] csum;

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  // Running XOR of bytes 0..22; it is complete by the time '*' is on the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     csum <= '0;
    else if (accept_start)          csum <= '0;
    else if (xfer && idx <= 5'd22)  csum <= csum ^ frame_byte;
  end
`endif

  always_comb begin
    frame_byte = 8'h00;
    case (idx)
      5'd0:  frame_byte = CH_T;
      5'd1:  frame_byte = dig(hour_bcd[7:4]);
      5'd2:  frame_byte = dig(hour_bcd[3:0]);
      5'd3:  frame_byte = CH_COLON;
      5'd4:  frame_byte = dig(min_bcd[7:4]);
      5'd5:  frame_byte = dig(min_bcd[3:0]);
      5'd6:  frame_byte = CH_COLON;
      5'd7:  frame_byte = dig(sec_bcd[7:4]);
      5'd8:  frame_byte = dig(sec_bcd[3:0]);
      5'd9:  frame_byte = SEP_CHAR;
      5'd10: frame_byte = CH_D;
      5'd11: frame_byte = dig(dist_bcd[15:12]);
      5'd12: frame_byte = dig(dist_bcd[11:8]);
      5'd13: frame_byte = dig(dist_bcd[7:4]);
      5'd14: frame_byte = dig(dist_bcd[3:0]);
      5'd15: frame_byte = SEP_CHAR;
      5'd16: frame_byte = CH_H;
      5'd17: frame_byte = dig(humi_bcd[7:4]);
      5'd18: frame_byte = dig(humi_bcd[3:0]);
      5'd19: frame_byte = SEP_CHAR;
      5'd20: frame_byte = CH_C;
      5'd21: frame_byte = dig(temp_bcd[7:4]);
      5'd22: frame_byte = dig(temp_bcd[3:0]);
`ifdef REPORT_CHECKSUM_EN
      5'd23: frame_byte = 8'h2A;
      5'd24: frame_byte = hexc(csum[7:4]);
      5'd25: frame_byte = hexc(csum[3:0]);
      5'd26: frame_byte = CH_CR;
      5'd27: frame_byte = CH_LF;
`else
      5'd23: frame_byte = CH_CR;
      5'd24: frame_byte = CH_LF;
`endif
      default: frame_byte = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_sensor_report_tx.sv
// Directed bench for sensor_report_tx: frame content, saturation, stalls, ignored starts, mid-frame reset.
module tb_sensor_report_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] i_hour, i_min, i_sec;
  logic [9:0] i_dist;
  logic [7:0] i_humi, i_temp;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready = 1'b1;
  logic       o_busy;
  logic       o_done;

  sensor_report_tx dut (
    .clk(clk), .reset(reset), .start(start),
    .i_hour(i_hour), .i_min(i_min), .i_sec(i_sec),
    .i_dist(i_dist), .i_humi(i_humi), .i_temp(i_temp),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [7:0] rx_q[$];
  int xfer_cyc[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int stall_err = 0;
  logic stalled_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit rdy_rand = 1'b0;
  int stall_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_tx_valid && i_tx_ready) begin
      rx_q.push_back(o_tx_data);
      xfer_cyc.push_back(cyc);
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (reset && stalled_prev && (!o_tx_valid || o_tx_data != prev_data)) stall_err++;
    stalled_prev = reset && o_tx_valid && !i_tx_ready;
    prev_data = o_tx_data;
  end

  // Ready pattern: random stalls of 1..5 cycles when enabled, otherwise held high.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rdy_rand) i_tx_ready = 1'b1;
      else if (stall_left > 0) begin
        i_tx_ready = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 2) == 0) begin
        i_tx_ready = 1'b0;
        stall_left = $urandom_range(0, 4);
      end else i_tx_ready = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic string add_cs(input string s);
`ifdef REPORT_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 23; i++) x ^= s[i];
    return {s.substr(0, 22), "*", $sformatf("%02X", x), "\r\n"};
`else
    return s;
`endif
  endfunction

  function automatic int xc(input int i);
    return (i < xfer_cyc.size()) ? xfer_cyc[i] : -1000;
  endfunction

  task automatic set_inputs(input int h, input int m, input int s, input int d, input int hu, input int t);
    i_hour = 6'(h); i_min = 6'(m); i_sec = 6'(s);
    i_dist = 10'(d); i_humi = 8'(hu); i_temp = 8'(t);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    xfer_cyc.delete();
  endtask

  task automatic pulse_start(output int s);
    @(posedge clk);
    #1 start = 1'b1;
    s = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int max_cyc);
    int n = 0;
    while (done_cnt == d0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic check_frame(input string tag, input string exp);
    chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp.len()));
    for (int i = 0; i < exp.len(); i++)
      chk($sformatf("%s_b%0d", tag, i), (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  task automatic run_frame(input string tag, input string exp, input int max_cyc, output int s);
    int d0;
    clear_rx();
    d0 = done_cnt;
    pulse_start(s);
    wait_done(tag, d0, max_cyc);
    repeat (4) @(posedge clk);
    check_frame(tag, exp);
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_done_lat"}, 32'(done_cyc - xc(exp.len() - 1)), 32'd1);
  endtask

  initial begin
    string f1, f2, f3;
    int s, d0;
    f1 = add_cs("T13:05:09 D0400 H45 C23\r\n");
    f2 = add_cs("T63:59:00 D1023 H99 C99\r\n");
    f3 = add_cs("T00:00:00 D0000 H99 C99\r\n");

    reset = 1'b0;
    start = 1'b0;
    set_inputs(13, 5, 9, 400, 45, 23);
    #3;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_valid", 32'(o_tx_valid), 32'd0);
    chk("rst_data", 32'(o_tx_data), 32'h00);
    chk("rst_done", 32'(o_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Nominal frame with ready held high: back-to-back bytes.
    run_frame("f1", f1, 100, s);
    chk("f1_start_lat", 32'(xc(0) - s), 32'd1);
    chk("f1_span", 32'(xc(f1.len() - 1) - xc(0)), 32'(f1.len() - 1));
    chk("f1_idle_busy", 32'(o_busy), 32'd0);

    // Saturation and full distance range.
    set_inputs(63, 59, 0, 1023, 150, 200);
    run_frame("f2", f2, 100, s);
    set_inputs(0, 0, 0, 0, 99, 100);
    run_frame("f3", f3, 100, s);

    // Random backpressure.
    set_inputs(13, 5, 9, 400, 45, 23);
    stall_err = 0;
    rdy_rand = 1'b1;
    run_frame("stall", f1, 400, s);
    chk("stall_hold", 32'(stall_err), 32'd0);
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);

    // Starts during a frame are ignored; inputs change mid-frame.
    clear_rx();
    d0 = done_cnt;
    pulse_start(s);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    set_inputs(1, 2, 3, 4, 5, 6);
    repeat (20) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ign", d0, 100);
    repeat (30) @(posedge clk);
    check_frame("ign", f1);
    chk("ign_done_once", 32'(done_cnt - d0), 32'd1);
    chk("ign_idle_busy", 32'(o_busy), 32'd0);

    // Asynchronous reset while byte 10 is presented.
    set_inputs(13, 5, 9, 400, 45, 23);
    clear_rx();
    pulse_start(s);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_idx10", 32'(o_tx_data), 32'h44);
    #2 reset = 1'b0;
    #1;
    chk("mid_busy", 32'(o_busy), 32'd0);
    chk("mid_valid", 32'(o_tx_valid), 32'd0);
    chk("mid_data", 32'(o_tx_data), 32'h00);
    chk("mid_done", 32'(o_done), 32'd0);
    #2 reset = 1'b1;
    clear_rx();
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(o_busy), 32'd0);
    chk("post_rst_rx", 32'(rx_q.size()), 32'd0);
    run_frame("rst", f1, 100, s);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
